// File: rtl/md_sequencer.sv
// Iterative multiply/divide sequencer owning the HI/LO pair; one shared adder over WIDTH steps.
// Optional divide support is enabled by defining MD_DIV_EN; otherwise div/divu complete as no-ops.
module md_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state;

  logic             div_q;
  logic             neg_res;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [CW-1:0]    count;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign a_neg    = ~op[0] & a[WIDTH-1];
  assign b_neg    = ~op[0] & b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign prod     = {acc, mq};
  assign prod_fix = neg_res ? -prod : prod;

`ifdef MD_DIV_EN
  logic             neg_rem;
  logic             dz;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH:0]   add_x, add_y;
  logic             add_cin;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Divide reuses the adder as a subtractor; sum[WIDTH+1] is the no-borrow flag.
  always_comb begin
    add_x   = {1'b0, acc};
    add_y   = mq[0] ? {1'b0, opb} : '0;
    add_cin = 1'b0;
    if (div_q) begin
      add_x   = {acc, mq[WIDTH-1]};
      add_y   = ~{1'b0, opb};
      add_cin = 1'b1;
    end
  end

  assign sum     = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
  assign quo_fix = neg_res ? -mq : mq;
  assign rem_fix = neg_rem ? -acc : acc;
`else
  logic [WIDTH:0] sum;

  assign sum = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      div_q   <= 1'b0;
      neg_res <= 1'b0;
      opb     <= '0;
      acc     <= '0;
      mq      <= '0;
      count   <= '0;
`ifdef MD_DIV_EN
      div_by_zero <= 1'b0;
      neg_rem     <= 1'b0;
      dz          <= 1'b0;
      a_raw       <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MD_DIV_EN
      div_by_zero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (hi_wr) hi <= wr_data;
          if (lo_wr) lo <= wr_data;
          if (start) begin
            div_q   <= op[1];
            neg_res <= a_neg ^ b_neg;
            opb     <= b_mag;
            mq      <= a_mag;
            acc     <= '0;
            count   <= '0;
            busy    <= 1'b1;
`ifdef MD_DIV_EN
            neg_rem <= a_neg;
            dz      <= (b == '0);
            a_raw   <= a;
            state   <= RUN;
`else
            state   <= op[1] ? FIX : RUN;
`endif
          end
        end
        RUN: begin
          count <= count + CW'(1);
`ifdef MD_DIV_EN
          if (div_q) begin
            acc <= sum[WIDTH+1] ? sum[WIDTH-1:0] : add_x[WIDTH-1:0];
            mq  <= {mq[WIDTH-2:0], sum[WIDTH+1]};
          end else begin
            acc <= sum[WIDTH:1];
            mq  <= {sum[0], mq[WIDTH-1:1]};
          end
`else
          acc <= sum[WIDTH:1];
          mq  <= {sum[0], mq[WIDTH-1:1]};
`endif
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!div_q) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
`ifdef MD_DIV_EN
          else if (dz) begin
            hi          <= a_raw;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: reset, mthi/mtlo, signed/unsigned multiply, ignored
// requests while busy, mid-operation reset, and divide (full or stubbed per MD_DIV_EN).
module tb_md_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_wr = 1'b0;
  logic         lo_wr = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  md_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Drives a start pulse at a falling edge; returns at the falling edge after edge E.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic wlo, input logic [W-1:0] wd);
    op = o; a = x; b = y; start = 1'b1; lo_wr = wlo; wr_data = wd;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; lo_wr = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic wlo, input logic [W-1:0] wd,
                        input int exp_lat, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dz);
    int lat;
    issue(o, x, y, wlo, wd);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    if (wlo) check({tag, "_lo_wr"}, lo, wd);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    exp_q.push_back(exp_hi);
    exp_q.push_back(exp_lo);
    check({tag, "_latency"}, W'(lat), W'(exp_lat));
    check({tag, "_hi"}, hi, exp_q.pop_front());
    check({tag, "_lo"}, lo, exp_q.pop_front());
    check({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, exp_dz});
    @(negedge clk);
    check({tag, "_done_once"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int first_done;
    int n_done;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_by_zero}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    lo_wr = 1'b1; wr_data = 32'h0000_1234;
    @(negedge clk);
    lo_wr = 1'b0;
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_hi", hi, 32'h0);

    hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hA5A5_0001;
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b0;
    check("mthilo_hi", hi, 32'hA5A5_0001);
    check("mthilo_lo", lo, 32'hA5A5_0001);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, '0, 33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("mult_m1x2", 2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0, '0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, '0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("mult_m3xm5", 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0, '0, 33, 32'h0, 32'd15, 1'b0);
    run_op("multu_2p32", 2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0, '0, 33, 32'h0000_0001, 32'h0, 1'b0);

    // 3*4 with a stray start and mthi mid-run; HI/LO must hold until FIX.
    issue(2'b00, 32'd3, 32'd4, 1'b0, '0);
    repeat (4) @(negedge clk);
    check("run_busy", {31'd0, busy}, 32'd1);
    check("run_hold_hi", hi, 32'h0000_0001);
    check("run_hold_lo", lo, 32'h0);
    op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    hi_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_wr = 1'b0;
    check("run_drop_hi", hi, 32'h0000_0001);
    first_done = 0;
    n_done = 0;
    for (int i = 6; i <= 45; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = i;
      end
      if (i == 33) begin
        check("m3x4_hi", hi, 32'h0);
        check("m3x4_lo", lo, 32'd12);
      end
    end
    check("m3x4_first_done", W'(first_done), 32'd33);
    check("m3x4_done_count", W'(n_done), 32'd1);

    // Asynchronous reset mid-multiply.
    issue(2'b00, 32'd5, 32'd5, 1'b0, '0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst_no_done", W'(n_done), 32'd0);
    check("midrst_idle", {31'd0, busy}, 32'd0);

    // start with mtlo in IDLE: the write lands, then FIX overwrites it.
    run_op("mult_6x7", 2'b00, 32'd6, 32'd7, 1'b1, 32'h0000_0055, 33, 32'h0, 32'd42, 1'b0);

`ifdef MD_DIV_EN
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, '0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7_2", 2'b11, 32'd7, 32'd2, 1'b0, '0, 33, 32'd1, 32'd3, 1'b0);
    run_op("divu_5_0", 2'b11, 32'd5, 32'd0, 1'b0, '0, 33, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("div_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, '0, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0, 33, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'h0001_0000, 1'b0, '0, 33, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
`else
    run_op("divu_stub", 2'b11, 32'd7, 32'd2, 1'b0, '0, 1, 32'h0, 32'd42, 1'b0);
    run_op("div_stub0", 2'b10, 32'd5, 32'd0, 1'b0, '0, 1, 32'h0, 32'd42, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
